fft_out_framer: RTL and testbench

Frame collector on the output side of the 32-point FFT core. Accepts the core's free-running `out_valid`/`dout_r`/`dout_i` sample stream, which has no backpressure, and stores complete 32-sample frames in two ping-pong banks. It then replays each frame to a downstream consumer over a valid/ready handshake, together with the frame's total energy. Incoming frames are dropped and counted when both banks are occupied.

---
 rtl/fft_pkg.sv | 35 +++
 rtl/fft_energy_acc.sv | 42 ++++
 rtl/fft_out_framer.sv | 167 ++++++++++++++++
 tb/tb_fft_out_framer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT output framer.
// FFT_OUT_BITREV_EN selects bit-reversed write addressing in fft_out_framer.
package fft_pkg;

  localparam int FFT_SIZE = 32;
  localparam int IDX_W    = $clog2(FFT_SIZE);
  localparam int DATA_W   = 16;

  typedef struct packed {
    logic signed [DATA_W-1:0] r;
    logic signed [DATA_W-1:0] i;
  } sample_t;

  typedef logic [1:0] wr_state_t;
  typedef logic [0:0] rd_state_t;

  localparam wr_state_t WR_IDLE = 2'd0;
  localparam wr_state_t WR_FILL = 2'd1;
  localparam wr_state_t WR_DROP = 2'd2;

  localparam rd_state_t RD_IDLE = 1'b0;
  localparam rd_state_t RD_SEND = 1'b1;

  function automatic logic [IDX_W-1:0] bitrev(
    input logic [IDX_W-1:0] x
  );
    logic [IDX_W-1:0] y;
    y = '0;
    for (int b = 0; b < IDX_W; b++) begin
      y[b] = x[IDX_W-1-b];
    end
    return y;
  endfunction

endpackage

// File: rtl/fft_energy_acc.sv
// Squaring accumulator: o_sum is the running energy including
// the current sample, restarting from zero when i_clr is high.
module fft_energy_acc
  import fft_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ENERGY_W = 40
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_clr,
  input  logic                       i_en,
  input  logic signed [DATA_W-1:0]   i_r,
  input  logic signed [DATA_W-1:0]   i_i,
  output logic        [ENERGY_W-1:0] o_sum
);

  logic signed [2*DATA_W-1:0] w_rr;
  logic signed [2*DATA_W-1:0] w_ii;
  logic        [ENERGY_W-1:0] w_sq;
  logic        [ENERGY_W-1:0] w_base;
  logic        [ENERGY_W-1:0] r_acc;

  // Squares are non-negative, so the unsigned view is exact.
  assign w_rr = (2*DATA_W)'(i_r) * (2*DATA_W)'(i_r);
  assign w_ii = (2*DATA_W)'(i_i) * (2*DATA_W)'(i_i);

  assign w_sq = ENERGY_W'($unsigned(w_rr))
              + ENERGY_W'($unsigned(w_ii));

  assign w_base = i_clr ? '0 : r_acc;
  assign o_sum  = w_base + w_sq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_sum;
    end
  end

endmodule

// File: rtl/fft_out_framer.sv
// Ping-pong frame collector and replayer for the FFT output stream.
// Define FFT_OUT_BITREV_EN to store samples at bit-reversed addresses.
module fft_out_framer
  import fft_pkg::*;
#(
  parameter int FFT_SIZE = fft_pkg::FFT_SIZE,
  parameter int DATA_W   = fft_pkg::DATA_W,
  parameter int ENERGY_W = 40,
  localparam int IW      = $clog2(FFT_SIZE)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fft_valid,
  input  logic signed [DATA_W-1:0]   fft_r,
  input  logic signed [DATA_W-1:0]   fft_i,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DATA_W-1:0]   dout_r,
  output logic signed [DATA_W-1:0]   dout_i,
  output logic        [IW-1:0]       out_index,
  output logic                       out_last,
  output logic        [ENERGY_W-1:0] frame_energy,
  output logic        [7:0]          drop_cnt,
  output logic                       busy
);

  localparam logic [IW-1:0] LAST = IW'(FFT_SIZE-1);

  wr_state_t              r_wr_state;
  logic                   r_wr_bank;
  logic                   r_rd_bank;
  logic [IW-1:0]          r_wr_idx;
  logic [IW-1:0]          r_rd_idx;
  logic [1:0]             r_full;
  logic [7:0]             r_drop_cnt;
  logic [ENERGY_W-1:0]    r_energy [2];
  logic signed [DATA_W-1:0] r_mem_r [2][FFT_SIZE];
  logic signed [DATA_W-1:0] r_mem_i [2][FFT_SIZE];

  rd_state_t              w_rd_state;
  logic                   w_rd_valid;
  logic                   w_rd_last;
  logic                   w_rd_hs;
  logic                   w_release;
  logic                   w_wr_free;
  logic                   w_idle;
  logic                   w_wr_en;
  logic                   w_wr_done;
  logic [IW-1:0]          w_wr_pos;
  logic [IW-1:0]          w_wr_addr;
  logic [ENERGY_W-1:0]    w_acc_sum;

  assign w_rd_state = r_full[r_rd_bank] ? RD_SEND : RD_IDLE;
  assign w_rd_valid = (w_rd_state == RD_SEND);
  assign w_rd_last  = (r_rd_idx == LAST);
  assign w_rd_hs    = w_rd_valid && out_ready;
  assign w_release  = w_rd_hs && w_rd_last;

  // A bank being released this cycle may take a new frame at once.
  assign w_wr_free = !r_full[r_wr_bank]
                  || (w_release && (r_rd_bank == r_wr_bank));

  assign w_idle    = (r_wr_state == WR_IDLE);
  assign w_wr_pos  = w_idle ? '0 : r_wr_idx;
  assign w_wr_en   = fft_valid
                  && ((w_idle && w_wr_free)
                   || (r_wr_state == WR_FILL));
  assign w_wr_done = fft_valid && (r_wr_state == WR_FILL)
                  && (r_wr_idx == LAST);

`ifdef FFT_OUT_BITREV_EN
  always_comb begin
    w_wr_addr = '0;
    for (int b = 0; b < IW; b++) begin
      w_wr_addr[b] = w_wr_pos[IW-1-b];
    end
  end
`else
  assign w_wr_addr = w_wr_pos;
`endif

  fft_energy_acc #(
    .DATA_W   (DATA_W),
    .ENERGY_W (ENERGY_W)
  ) u_acc (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_idle),
    .i_en  (w_wr_en),
    .i_r   (fft_r),
    .i_i   (fft_i),
    .o_sum (w_acc_sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_state <= WR_IDLE;
      r_wr_idx   <= '0;
      r_wr_bank  <= 1'b0;
      r_drop_cnt <= '0;
    end else if (fft_valid) begin
      unique case (r_wr_state)
        WR_IDLE: begin
          r_wr_idx   <= IW'(1);
          r_wr_state <= w_wr_free ? WR_FILL : WR_DROP;
        end
        WR_FILL: begin
          r_wr_idx <= r_wr_idx + IW'(1);
          if (r_wr_idx == LAST) begin
            r_wr_state <= WR_IDLE;
            r_wr_bank  <= ~r_wr_bank;
          end
        end
        WR_DROP: begin
          r_wr_idx <= r_wr_idx + IW'(1);
          if (r_wr_idx == LAST) begin
            r_wr_state <= WR_IDLE;
            if (r_drop_cnt != 8'hFF) begin
              r_drop_cnt <= r_drop_cnt + 8'd1;
            end
          end
        end
        default: r_wr_state <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem_r[r_wr_bank][w_wr_addr] <= fft_r;
      r_mem_i[r_wr_bank][w_wr_addr] <= fft_i;
    end
  end

  // Read only releases a full bank and write only fills a free one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_full      <= '0;
      r_rd_bank   <= 1'b0;
      r_rd_idx    <= '0;
      r_energy[0] <= '0;
      r_energy[1] <= '0;
    end else begin
      if (w_rd_hs) begin
        r_rd_idx <= r_rd_idx + IW'(1);
        if (w_rd_last) begin
          r_full[r_rd_bank] <= 1'b0;
          r_rd_bank         <= ~r_rd_bank;
        end
      end
      if (w_wr_done) begin
        r_full[r_wr_bank]   <= 1'b1;
        r_energy[r_wr_bank] <= w_acc_sum;
      end
    end
  end

  assign out_valid    = w_rd_valid;
  assign out_index    = r_rd_idx;
  assign out_last     = w_rd_valid && w_rd_last;
  assign dout_r       = w_rd_valid ? r_mem_r[r_rd_bank][r_rd_idx] : '0;
  assign dout_i       = w_rd_valid ? r_mem_i[r_rd_bank][r_rd_idx] : '0;
  assign frame_energy = w_rd_valid ? r_energy[r_rd_bank] : '0;
  assign drop_cnt     = r_drop_cnt;
  assign busy         = !w_idle || (|r_full);

endmodule

// File: tb/tb_fft_out_framer.sv
// Directed self-checking bench for fft_out_framer.
// Expected data comes from the bench's own frame tables.
module tb_fft_out_framer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fft_valid = 1'b0;
  logic [15:0] fft_r = '0;
  logic [15:0] fft_i = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] dout_r;
  logic [15:0] dout_i;
  logic [4:0]  out_index;
  logic        out_last;
  logic [39:0] frame_energy;
  logic [7:0]  drop_cnt;
  logic        busy;

  fft_out_framer dut (
    .clk          (clk),
    .reset        (reset),
    .fft_valid    (fft_valid),
    .fft_r        (fft_r),
    .fft_i        (fft_i),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .dout_r       (dout_r),
    .dout_i       (dout_i),
    .out_index    (out_index),
    .out_last     (out_last),
    .frame_energy (frame_energy),
    .drop_cnt     (drop_cnt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int stall_err = 0;

  logic [15:0] frm_r [4][32];
  logic [15:0] frm_i [4][32];

  logic [15:0] q_r [$];
  logic [15:0] q_i [$];
  logic [4:0]  q_idx [$];
  bit          q_last [$];
  logic [39:0] q_en [$];
  int          q_cyc [$];

  bit          p_valid = 1'b0;
  bit          p_ready = 1'b0;
  logic [15:0] p_r, p_i;
  logic [4:0]  p_idx;
  logic [39:0] p_en;

  // Arrival index of the sample expected at natural bin m.
  function automatic int src(int m);
`ifdef FFT_OUT_BITREV_EN
    int y = 0;
    for (int b = 0; b < 5; b++) if (m[b]) y |= (1 << (4 - b));
    return y;
`else
    return m;
`endif
  endfunction

  function automatic longint e_of(int f);
    longint s = 0;
    for (int k = 0; k < 32; k++) begin
      longint a = longint'($signed(frm_r[f][k]));
      longint b = longint'($signed(frm_i[f][k]));
      s += a * a + b * b;
    end
    return s;
  endfunction

  task automatic clear_q();
    q_r.delete(); q_i.delete(); q_idx.delete();
    q_last.delete(); q_en.delete(); q_cyc.delete();
  endtask

  // One cycle: drive inputs, log a handshake due at the next edge,
  // and count any output change during a stall.
  task automatic step(input bit v, input logic [15:0] r,
                      input logic [15:0] im, input bit rdy);
    @(negedge clk);
    cyc++;
    if (p_valid && !p_ready) begin
      if (!out_valid || dout_r !== p_r || dout_i !== p_i ||
          out_index !== p_idx || frame_energy !== p_en)
        stall_err++;
    end
    fft_valid = v; fft_r = r; fft_i = im; out_ready = rdy;
    if (out_valid && rdy) begin
      q_r.push_back(dout_r); q_i.push_back(dout_i);
      q_idx.push_back(out_index); q_last.push_back(out_last);
      q_en.push_back(frame_energy); q_cyc.push_back(cyc);
    end
    p_valid = out_valid; p_ready = rdy;
    p_r = dout_r; p_i = dout_i; p_idx = out_index; p_en = frame_energy;
  endtask

  task automatic feed(input int f, input int n, input bit rdy);
    for (int k = 0; k < n; k++) step(1'b1, frm_r[f][k], frm_i[f][k], rdy);
  endtask

  task automatic drain(input int n);
    for (int c = 0; c < n; c++) step(1'b0, 16'h0, 16'h0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; fft_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    p_valid = 1'b0;
    clear_q();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b want 0", out_last); end
    n_cmp++; if (out_index !== 5'd0) begin n_fail++; $display("FAIL reset_index got %0d want 0", out_index); end
    n_cmp++; if (dout_r !== 16'd0 || dout_i !== 16'd0) begin n_fail++; $display("FAIL reset_dout got %h/%h want 0/0", dout_r, dout_i); end
    n_cmp++; if (frame_energy !== 40'd0) begin n_fail++; $display("FAIL reset_energy got %0d want 0", frame_energy); end
    n_cmp++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_single_frame();
    do_reset();
    for (int k = 0; k < 32; k++) begin
      frm_r[0][k] = 16'(k); frm_i[0][k] = 16'(-k);
    end
    feed(0, 32, 1'b1);
    n_cmp++; if (q_r.size() !== 0) begin n_fail++; $display("FAIL single_early got %0d outputs want 0", q_r.size()); end
    step(1'b0, 16'h0, 16'h0, 1'b1);
    n_cmp++; if (q_r.size() !== 1) begin n_fail++; $display("FAIL single_latency got %0d outputs want 1", q_r.size()); end
    drain(40);
    n_cmp++; if (q_r.size() !== 32) begin n_fail++; $display("FAIL single_count got %0d want 32", q_r.size()); end
    for (int m = 0; m < 32 && m < q_r.size(); m++) begin
      n_cmp++;
      if (q_r[m] !== frm_r[0][src(m)] || q_i[m] !== frm_i[0][src(m)] ||
          q_idx[m] !== 5'(m) || q_last[m] !== (m == 31) ||
          q_en[m] !== 40'(e_of(0))) begin
        n_fail++;
        $display("FAIL single_data m=%0d got r=%h i=%h idx=%0d last=%b e=%0d want r=%h i=%h e=%0d",
                 m, q_r[m], q_i[m], q_idx[m], q_last[m], q_en[m],
                 frm_r[0][src(m)], frm_i[0][src(m)], e_of(0));
      end
    end
    n_cmp++; if (q_r.size() >= 32 && q_cyc[31] - q_cyc[0] !== 31) begin n_fail++; $display("FAIL single_span got %0d want 31", q_cyc[31] - q_cyc[0]); end
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle got busy=%b valid=%b want 0/0", busy, out_valid); end
  endtask

  task automatic test_gaps_throttle();
    do_reset();
    stall_err = 0;
    for (int k = 0; k < 32; k++) begin
      frm_r[0][k] = 16'(1000 - 37 * k); frm_i[0][k] = 16'(3 * k - 50);
    end
    for (int k = 0; k < 32; k++) begin
      step(1'b1, frm_r[0][k], frm_i[0][k], 1'($urandom_range(0, 1)));
      for (int g = 0; g < 3; g++)
        step(1'b0, 16'h0, 16'h0, 1'($urandom_range(0, 1)));
    end
    for (int c = 0; c < 400 && q_r.size() < 32; c++)
      step(1'b0, 16'h0, 16'h0, 1'($urandom_range(0, 1)));
    n_cmp++; if (q_r.size() !== 32) begin n_fail++; $display("FAIL gaps_count got %0d want 32", q_r.size()); end
    for (int m = 0; m < 32 && m < q_r.size(); m++) begin
      n_cmp++;
      if (q_r[m] !== frm_r[0][src(m)] || q_i[m] !== frm_i[0][src(m)] ||
          q_idx[m] !== 5'(m) || q_en[m] !== 40'(e_of(0))) begin
        n_fail++;
        $display("FAIL gaps_data m=%0d got r=%h i=%h idx=%0d e=%0d want r=%h i=%h e=%0d",
                 m, q_r[m], q_i[m], q_idx[m], q_en[m],
                 frm_r[0][src(m)], frm_i[0][src(m)], e_of(0));
      end
    end
    n_cmp++; if (stall_err !== 0) begin n_fail++; $display("FAIL gaps_stall got %0d changes want 0", stall_err); end
  endtask

  task automatic test_drop_and_replay();
    do_reset();
    feed(1, 32, 1'b0);
    feed(2, 32, 1'b0);
    feed(3, 32, 1'b0);
    n_cmp++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL drop_before got %0d want 0", drop_cnt); end
    step(1'b0, 16'h0, 16'h0, 1'b0);
    n_cmp++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL drop_count got %0d want 1", drop_cnt); end
    n_cmp++; if (out_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL drop_hold got valid=%b busy=%b want 1/1", out_valid, busy); end
    n_cmp++; if (frame_energy !== 40'(e_of(1))) begin n_fail++; $display("FAIL drop_energy got %0d want %0d", frame_energy, e_of(1)); end
    drain(80);
    n_cmp++; if (q_r.size() !== 64) begin n_fail++; $display("FAIL drop_replay_count got %0d want 64", q_r.size()); end
    for (int m = 0; m < 64 && m < q_r.size(); m++) begin
      int f = 1 + m / 32;
      int j = m % 32;
      n_cmp++;
      if (q_r[m] !== frm_r[f][src(j)] || q_i[m] !== frm_i[f][src(j)] ||
          q_idx[m] !== 5'(j) || q_last[m] !== (j == 31) ||
          q_en[m] !== 40'(e_of(f))) begin
        n_fail++;
        $display("FAIL drop_replay f=%0d m=%0d got r=%h i=%h idx=%0d e=%0d want r=%h i=%h e=%0d",
                 f, j, q_r[m], q_i[m], q_idx[m], q_en[m],
                 frm_r[f][src(j)], frm_i[f][src(j)], e_of(f));
      end
    end
    n_cmp++; if (q_r.size() >= 64 && q_cyc[63] - q_cyc[0] !== 63) begin n_fail++; $display("FAIL drop_bubble got span %0d want 63", q_cyc[63] - q_cyc[0]); end
    n_cmp++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL drop_after got %0d want 1", drop_cnt); end
  endtask

  task automatic test_release_start();
    do_reset();
    feed(1, 32, 1'b0);
    feed(2, 32, 1'b0);
    drain(31);
    // This sample starts frame 3 on the edge that accepts out_last.
    feed(3, 32, 1'b1);
    step(1'b0, 16'h0, 16'h0, 1'b1);
    n_cmp++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL release_drop got %0d want 0", drop_cnt); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL release_busy got %b want 1", busy); end
    drain(40);
    n_cmp++; if (q_r.size() !== 96) begin n_fail++; $display("FAIL release_count got %0d want 96", q_r.size()); end
    for (int m = 0; m < 96 && m < q_r.size(); m++) begin
      int f = 1 + m / 32;
      int j = m % 32;
      n_cmp++;
      if (q_r[m] !== frm_r[f][src(j)] || q_i[m] !== frm_i[f][src(j)] ||
          q_idx[m] !== 5'(j) || q_en[m] !== 40'(e_of(f))) begin
        n_fail++;
        $display("FAIL release_data f=%0d m=%0d got r=%h i=%h idx=%0d e=%0d want r=%h i=%h e=%0d",
                 f, j, q_r[m], q_i[m], q_idx[m], q_en[m],
                 frm_r[f][src(j)], frm_i[f][src(j)], e_of(f));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 32; k++) begin
      frm_r[0][k] = 16'(7 * k - 90); frm_i[0][k] = 16'(500 + k);
    end
    feed(1, 32, 1'b0);
    feed(2, 32, 1'b0);
    feed(3, 32, 1'b0);
    drain(32);
    feed(0, 16, 1'b1);
    n_cmp++; if (drop_cnt !== 8'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_pre got drop=%0d busy=%b want 1/1", drop_cnt, busy); end
    @(negedge clk);
    reset = 1'b1; fft_valid = 1'b1;
    fft_r = frm_r[0][16]; fft_i = frm_i[0][16]; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", out_valid); end
    n_cmp++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_drop got %0d want 0", drop_cnt); end
    n_cmp++; if (out_index !== 5'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_state got idx=%0d busy=%b want 0/0", out_index, busy); end
    reset = 1'b0; fft_valid = 1'b0; out_ready = 1'b0;
    p_valid = 1'b0;
    clear_q();
    drain(5);
    n_cmp++; if (q_r.size() !== 0) begin n_fail++; $display("FAIL mid_ghost got %0d outputs want 0", q_r.size()); end
    feed(2, 32, 1'b1);
    drain(40);
    n_cmp++; if (q_r.size() !== 32) begin n_fail++; $display("FAIL mid_fresh_count got %0d want 32", q_r.size()); end
    for (int m = 0; m < 32 && m < q_r.size(); m++) begin
      n_cmp++;
      if (q_r[m] !== frm_r[2][src(m)] || q_i[m] !== frm_i[2][src(m)] ||
          q_idx[m] !== 5'(m) || q_en[m] !== 40'(e_of(2))) begin
        n_fail++;
        $display("FAIL mid_fresh m=%0d got r=%h i=%h e=%0d want r=%h i=%h e=%0d",
                 m, q_r[m], q_i[m], q_en[m],
                 frm_r[2][src(m)], frm_i[2][src(m)], e_of(2));
      end
    end
  endtask

  task automatic test_bitrev_order();
    do_reset();
    for (int k = 0; k < 32; k++) begin
      frm_r[0][k] = 16'(k); frm_i[0][k] = 16'h0;
    end
    feed(0, 32, 1'b1);
    drain(40);
    n_cmp++; if (q_r.size() !== 32) begin n_fail++; $display("FAIL order_count got %0d want 32", q_r.size()); end
    for (int m = 0; m < 32 && m < q_r.size(); m++) begin
      n_cmp++;
      if (q_r[m] !== 16'(src(m)) || q_idx[m] !== 5'(m)) begin
        n_fail++;
        $display("FAIL order m=%0d got r=%0d idx=%0d want r=%0d",
                 m, q_r[m], q_idx[m], src(m));
      end
    end
  endtask

  initial begin
    for (int f = 1; f < 4; f++) begin
      for (int k = 0; k < 32; k++) begin
        frm_r[f][k] = 16'(f * 256 + k);
        frm_i[f][k] = 16'(k * f - 40);
      end
    end
    test_reset();
    test_single_frame();
    test_gaps_throttle();
    test_drop_and_replay();
    test_release_start();
    test_reset_mid();
    test_bitrev_order();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
